// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath width, register address width and control bit map.
`default_nettype none

package cpu_pkg;
  localparam int XLEN           = 32;
  localparam int REG_AW         = 5;
  localparam int CTRL_W         = 8;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
`default_nettype none

module load_use_detect
  import cpu_pkg::*;
(
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  output logic              o_hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign o_hazard = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0) & i_id_valid &
                    ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, backpressure, flush and bubble counter.
// Optional macro ID_EX_WB_BYPASS_EN forwards same-cycle writeback data into the captured operands.
`default_nettype none

module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic [XLEN-1:0]   i_id_data_a,
  input  logic [XLEN-1:0]   i_id_data_b,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic              i_ex_ready,
  input  logic              i_flush_in,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [XLEN-1:0]   o_ex_data_a,
  output logic [XLEN-1:0]   o_ex_data_b,
  output logic [REG_AW-1:0] o_ex_rs1,
  output logic [REG_AW-1:0] o_ex_rs2,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_stall_id,
  output logic [CNT_W-1:0]  o_bubble_count
);

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [XLEN-1:0]   r_ex_data_a;
  logic [XLEN-1:0]   r_ex_data_b;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_flush_pending;
  logic [CNT_W-1:0]  r_bubble_count;

  logic              w_hazard;
  logic              w_eff_flush;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_ex_valid),
    .i_ex_mem_read (r_ex_ctrl[CTRL_MEM_READ]),
    .i_ex_rd       (r_ex_rd),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .o_hazard      (w_hazard)
  );

  assign o_stall_id  = w_hazard | ~i_ex_ready;
  assign w_eff_flush = i_flush_in | r_flush_pending;

`ifdef ID_EX_WB_BYPASS_EN
  // Register file writes on the rising edge, so its read port still shows the old value this cycle.
  assign w_op_a = (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_id_rs1)) ? i_wb_data : i_id_data_a;
  assign w_op_b = (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_id_rs2)) ? i_wb_data : i_id_data_b;
`else
  assign w_op_a = i_id_data_a;
  assign w_op_b = i_id_data_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= '0;
      r_ex_imm        <= '0;
      r_ex_data_a     <= '0;
      r_ex_data_b     <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
      r_ex_ctrl       <= '0;
      r_flush_pending <= 1'b0;
      r_bubble_count  <= '0;
    end else if (!i_ex_ready) begin
      // A flush arriving while EX is stalled must still squash the slot once EX frees up.
      if (i_flush_in) r_flush_pending <= 1'b1;
    end else begin
      r_flush_pending <= 1'b0;
      if (w_eff_flush || w_hazard) begin
        r_ex_valid  <= 1'b0;
        r_ex_pc     <= '0;
        r_ex_imm    <= '0;
        r_ex_data_a <= '0;
        r_ex_data_b <= '0;
        r_ex_rs1    <= '0;
        r_ex_rs2    <= '0;
        r_ex_rd     <= '0;
        r_ex_ctrl   <= '0;
        if (!w_eff_flush && (r_bubble_count != {CNT_W{1'b1}}))
          r_bubble_count <= r_bubble_count + 1'b1;
      end else begin
        r_ex_valid  <= i_id_valid;
        r_ex_pc     <= i_id_pc;
        r_ex_imm    <= i_id_imm;
        r_ex_data_a <= w_op_a;
        r_ex_data_b <= w_op_b;
        r_ex_rs1    <= i_id_rs1;
        r_ex_rs2    <= i_id_rs2;
        r_ex_rd     <= i_id_rd;
        r_ex_ctrl   <= i_id_valid ? i_id_ctrl : '0;
      end
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_pc        = r_ex_pc;
  assign o_ex_imm       = r_ex_imm;
  assign o_ex_data_a    = r_ex_data_a;
  assign o_ex_data_b    = r_ex_data_b;
  assign o_ex_rs1       = r_ex_rs1;
  assign o_ex_rs2       = r_ex_rs2;
  assign o_ex_rd        = r_ex_rd;
  assign o_ex_ctrl      = r_ex_ctrl;
  assign o_bubble_count = r_bubble_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; bubble counter is built 8 bits wide to reach saturation quickly.
`default_nettype none

module tb_id_ex_stage;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              i_id_valid;
  logic [XLEN-1:0]   i_id_pc;
  logic [4:0]        i_id_rs1, i_id_rs2, i_id_rd;
  logic [XLEN-1:0]   i_id_data_a, i_id_data_b, i_id_imm;
  logic [CTRL_W-1:0] i_id_ctrl;
  logic              i_ex_ready, i_flush_in, i_wb_we;
  logic [4:0]        i_wb_rd;
  logic [XLEN-1:0]   i_wb_data;
  logic              o_ex_valid;
  logic [XLEN-1:0]   o_ex_pc, o_ex_imm, o_ex_data_a, o_ex_data_b;
  logic [4:0]        o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic [CTRL_W-1:0] o_ex_ctrl;
  logic              o_stall_id;
  logic [CNT_W-1:0]  o_bubble_count;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_id_valid     (i_id_valid),
    .i_id_pc        (i_id_pc),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_rd        (i_id_rd),
    .i_id_data_a    (i_id_data_a),
    .i_id_data_b    (i_id_data_b),
    .i_id_imm       (i_id_imm),
    .i_id_ctrl      (i_id_ctrl),
    .i_ex_ready     (i_ex_ready),
    .i_flush_in     (i_flush_in),
    .i_wb_we        (i_wb_we),
    .i_wb_rd        (i_wb_rd),
    .i_wb_data      (i_wb_data),
    .o_ex_valid     (o_ex_valid),
    .o_ex_pc        (o_ex_pc),
    .o_ex_imm       (o_ex_imm),
    .o_ex_data_a    (o_ex_data_a),
    .o_ex_data_b    (o_ex_data_b),
    .o_ex_rs1       (o_ex_rs1),
    .o_ex_rs2       (o_ex_rs2),
    .o_ex_rd        (o_ex_rd),
    .o_ex_ctrl      (o_ex_ctrl),
    .o_stall_id     (o_stall_id),
    .o_bubble_count (o_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [7:0] ctrl);
    i_id_valid  = v;
    i_id_pc     = pc;
    i_id_rs1    = rs1;
    i_id_rs2    = rs2;
    i_id_rd     = rd;
    i_id_data_a = a;
    i_id_data_b = b;
    i_id_imm    = imm;
    i_id_ctrl   = ctrl;
  endtask

  logic [31:0] exp_a, exp_b;
  bit          reached;

  initial begin
    rst_n = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_ex_ready = 1'b1;
    i_flush_in = 1'b0;
    i_wb_we    = 1'b0;
    i_wb_rd    = 0;
    i_wb_data  = 0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", o_ex_valid, 0);
    check("rst_pc", o_ex_pc, 0);
    check("rst_ctrl", o_ex_ctrl, 0);
    check("rst_cnt", o_bubble_count, 0);
    check("rst_stall", o_stall_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain flow
    set_id(1, 32'h100, 3, 4, 9, 32'hAAAA0000, 32'h00005555, 32'h10, 8'h01);
    step();
    check("flow_valid", o_ex_valid, 1);
    check("flow_pc", o_ex_pc, 32'h100);
    check("flow_a", o_ex_data_a, 32'hAAAA0000);
    check("flow_b", o_ex_data_b, 32'h00005555);
    check("flow_imm", o_ex_imm, 32'h10);
    check("flow_rd", o_ex_rd, 9);
    check("flow_rs2", o_ex_rs2, 4);
    check("flow_ctrl", o_ex_ctrl, 8'h01);

    // Load-use on rs2 = load rd
    set_id(1, 32'h104, 1, 2, 5, 0, 0, 0, 8'h03);
    step();
    set_id(1, 32'h108, 6, 5, 8, 32'h11, 32'h22, 0, 8'h01);
    #1 check("lu_stall", o_stall_id, 1);
    step();
    check("lu_bubble_valid", o_ex_valid, 0);
    check("lu_bubble_ctrl", o_ex_ctrl, 0);
    check("lu_cnt", o_bubble_count, 1);
    check("lu_stall_drop", o_stall_id, 0);
    step();
    check("lu_dep_valid", o_ex_valid, 1);
    check("lu_dep_pc", o_ex_pc, 32'h108);

    // Load to x0 never stalls
    set_id(1, 32'h10C, 1, 2, 0, 0, 0, 0, 8'h03);
    step();
    set_id(1, 32'h110, 0, 0, 8, 0, 0, 0, 8'h01);
    #1 check("x0_stall", o_stall_id, 0);
    step();
    check("x0_pc", o_ex_pc, 32'h110);
    check("x0_cnt", o_bubble_count, 1);

    // Backpressure with a flush recorded during the stall
    set_id(1, 32'h114, 10, 11, 12, 0, 0, 0, 8'h01);
    i_ex_ready = 1'b0;
    i_flush_in = 1'b1;
    #1 check("bp_stall", o_stall_id, 1);
    step();
    i_flush_in = 1'b0;
    step();
    step();
    check("bp_hold_pc", o_ex_pc, 32'h110);
    check("bp_hold_valid", o_ex_valid, 1);
    check("bp_stall_held", o_stall_id, 1);
    i_ex_ready = 1'b1;
    step();
    check("bp_flush_valid", o_ex_valid, 0);
    check("bp_flush_pc", o_ex_pc, 0);
    check("bp_flush_cnt", o_bubble_count, 1);
    step();
    check("bp_resume_pc", o_ex_pc, 32'h114);

    // Flush and hazard together
    set_id(1, 32'h118, 1, 2, 5, 0, 0, 0, 8'h03);
    step();
    set_id(1, 32'h11C, 5, 0, 8, 0, 0, 0, 8'h01);
    i_flush_in = 1'b1;
    #1 check("fh_stall", o_stall_id, 1);
    step();
    i_flush_in = 1'b0;
    check("fh_valid", o_ex_valid, 0);
    check("fh_cnt", o_bubble_count, 1);
    step();
    check("fh_dep_pc", o_ex_pc, 32'h11C);

    // Writeback bypass
    set_id(1, 32'h120, 7, 7, 3, 32'h0, 32'h0000BBBB, 0, 8'h01);
    i_wb_we = 1'b1;
    i_wb_rd = 7;
    i_wb_data = 32'h12345678;
`ifdef ID_EX_WB_BYPASS_EN
    exp_a = 32'h12345678;
    exp_b = 32'h12345678;
`else
    exp_a = 32'h0;
    exp_b = 32'h0000BBBB;
`endif
    step();
    check("wb_a", o_ex_data_a, exp_a);
    check("wb_b", o_ex_data_b, exp_b);
    i_wb_we = 1'b0;

    // Invalid ID slot: control squashed to zero
    set_id(0, 32'h124, 1, 2, 3, 0, 0, 0, 8'hFF);
    step();
    check("inv_valid", o_ex_valid, 0);
    check("inv_ctrl", o_ex_ctrl, 0);
    check("inv_pc", o_ex_pc, 32'h124);

    // Counter saturation: back-to-back dependent loads
    set_id(1, 32'h128, 5, 5, 5, 0, 0, 0, 8'h03);
    reached = 0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      step();
      if (o_bubble_count == 8'hFE) reached = 1;
    end
    check("sat_reach_fe", reached, 1);
    for (int i = 0; i < 8; i++) step();
    check("sat_cnt", o_bubble_count, 8'hFF);

    // Asynchronous reset in the middle of a load-use stall
    reached = 0;
    for (int i = 0; i < 4 && !reached; i++) begin
      if (o_stall_id) reached = 1;
      else step();
    end
    check("ar_pre_stall", o_stall_id, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", o_ex_valid, 0);
    check("ar_ctrl", o_ex_ctrl, 0);
    check("ar_cnt", o_bubble_count, 0);
    check("ar_stall", o_stall_id, 0);
    i_ex_ready = 1'b0;
    #1 check("ar_stall_notready", o_stall_id, 1);
    i_ex_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
